matriz_soma_seq: RTL and testbench
==================================

Name: matriz_soma_seq

Overview:
- Sequential, parametrised matrix add/subtract engine for two square TAMANHO x TAMANHO matrices, A and B, of unsigned elements.
- Host loads A and B element by element through a write port, then pulses start.
- Block computes C = A + B or C = A - B, one element per accepted handshake, streaming C out in row-major order with valid/ready flow control.
- Arithmetic datapath building block for the matrix co-processor.

Parameters:
- TAMANHO, 5, matrix dimension (rows = cols), >= 1.
- LARGURA, 8, element width in bits, >= 2.
- IW, max(1,$clog2(TAMANHO)), row/column index width (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  element write strobe.
- wr_sel  input  1  target matrix: 0 = A, 1 = B.
- wr_lin  input  IW  write row index.
- wr_col  input  IW  write column index.
- wr_dado  input  LARGURA  write data.
- start  input  1  begin operation (level-sampled in IDLE).
- modo  input  1  0 = add, 1 = subtract; sampled with start.
- ocupado  output  1  high from cycle after start accepted until final handshake.
- out_valid  output  1  out_dado/out_lin/out_col/out_ultimo/estouro valid.
- out_ready  input  1  consumer accepts element.
- out_dado  output  LARGURA  result element C[lin][col].
- out_lin  output  IW  row of current element.
- out_col  output  IW  column of current element.
- out_ultimo  output  1  high with element (TAMANHO-1,TAMANHO-1).
- estouro  output  1  carry (add) or borrow (subtract) of current element.
- done  output  1  one-cycle pulse after final handshake.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; index counters 0; modo register 0; all A/B storage cleared to 0.
- Storage: 2 x TAMANHO x TAMANHO x LARGURA registers. A write occurs on a clk edge with wr_en=1 only when all of the following hold:
  - state IDLE;
  - start not accepted that cycle;
  - wr_lin < TAMANHO and wr_col < TAMANHO.
  Otherwise the write is silently dropped.
- FSM states:
  - IDLE: start=1 -> CALC; modo latched; indices cleared to (0,0); ocupado=1 and out_valid=1 from next cycle.
  - CALC: out_valid=1, outputs reflect the current index pair (combinational from storage or registered; the contract is what is visible while out_valid=1).
    - On out_valid & out_ready: advance col; wrap col to 0 and increment lin at TAMANHO-1.
    - If the handshake was on the last element -> IDLE, with ocupado=0, out_valid=0 and done=1 for exactly the next cycle.
- Backpressure: while out_valid & !out_ready, all out_* signals and estouro are held stable.
- Latency:
  - first element visible 1 cycle after start accepted;
  - with out_ready tied high, TAMANHO*TAMANHO consecutive elements, then done.
- start while ocupado=1 is ignored. modo changes mid-operation are ignored.
- Arithmetic: computed at LARGURA+1 bits.
  - Add: out_dado = (A+B) mod 2^LARGURA; estouro = bit LARGURA of the sum.
  - Subtract: out_dado = (A-B) mod 2^LARGURA; estouro = 1 iff A < B.
- TAMANHO=1: a single element with out_ultimo=1.
- Reset mid-operation: immediate return to IDLE, storage cleared, no done pulse.

Optional Feature:
- Macro: MATRIZ_SOMA_SATURATE_EN.
- Defined: saturating arithmetic. Add overflow -> out_dado = 2^LARGURA-1; subtract underflow -> out_dado = 0. estouro still flags the condition.
- Undefined: wrap-around as specified above. Port list identical in both builds.

Test Plan:
- Load A=B=4 in every element, start with modo=0, out_ready=1 -> 25 elements of 0x08, row-major (0,0)..(4,4), estouro=0, out_ultimo only on (4,4), done pulse one cycle after the 25th handshake, ocupado low the same cycle.
- A[0][0]=0xF0, B[0][0]=0x20, modo=0 -> element (0,0): out_dado=0x10, estouro=1; with MATRIZ_SOMA_SATURATE_EN: out_dado=0xFF, estouro=1.
- A[1][2]=3, B[1][2]=5, modo=1 -> element (1,2): out_dado=0xFE, estouro=1; saturating build: 0x00, estouro=1. A[0][0]=9, B[0][0]=2 -> 0x07, estouro=0.
- out_ready driven by pseudo-random pattern, A[i][j]=i*5+j, B=1, add -> all outputs stable while stalled; exactly 25 elements i*5+j+1, none lost or duplicated.
- Mid-stream: assert rst_n=0 after the 10th handshake -> out_valid, ocupado, done immediately 0; a new start yields 25 zeros.
- Negative cases, each -> ignored:
  - wr_en during ocupado;
  - wr_lin=5 or wr_col=7 with TAMANHO=5;
  - wr_en in the same cycle start is accepted;
  - start while ocupado (no restart, count continues to 25).
  Verify by results and handshake count.

Source files
------------

// File: rtl/matriz_soma_seq_if.sv
// Bundle of the host-side ports of the matrix add/subtract engine: element write port,
// start/mode control and the valid/ready result stream.
interface matriz_soma_seq_if #(
    parameter int TAMANHO = 5,
    parameter int LARGURA = 8
);
    localparam int IW = (TAMANHO > 1) ? $clog2(TAMANHO) : 1;

    logic               wr_en;
    logic               wr_sel;
    logic [IW-1:0]      wr_lin;
    logic [IW-1:0]      wr_col;
    logic [LARGURA-1:0] wr_dado;
    logic               start;
    logic               modo;
    logic               ocupado;
    logic               out_valid;
    logic               out_ready;
    logic [LARGURA-1:0] out_dado;
    logic [IW-1:0]      out_lin;
    logic [IW-1:0]      out_col;
    logic               out_ultimo;
    logic               estouro;
    logic               done;

    modport master (
        output wr_en, wr_sel, wr_lin, wr_col, wr_dado, start, modo, out_ready,
        input  ocupado, out_valid, out_dado, out_lin, out_col, out_ultimo, estouro, done
    );

    modport slave (
        input  wr_en, wr_sel, wr_lin, wr_col, wr_dado, start, modo, out_ready,
        output ocupado, out_valid, out_dado, out_lin, out_col, out_ultimo, estouro, done
    );
endinterface

// File: rtl/matriz_soma_seq.sv
// Sequential TAMANHO x TAMANHO matrix add/subtract engine: C = A +/- B streamed row-major.
// Optional build macro MATRIZ_SOMA_SATURATE_EN selects saturating instead of wrapping results.
module matriz_soma_seq #(
    parameter int TAMANHO = 5,
    parameter int LARGURA = 8
) (
    input logic             clk,
    input logic             rst_n,
    matriz_soma_seq_if.slave bus
);
    localparam int IW = (TAMANHO > 1) ? $clog2(TAMANHO) : 1;
    localparam logic [IW-1:0] ULT = IW'(TAMANHO - 1);

    typedef enum logic {IDLE, CALC} estado_t;

    estado_t            estado_q, estado_d;
    logic [IW-1:0]      lin_q, col_q;
    logic               modo_q;
    logic               done_q;
    logic [LARGURA-1:0] mem_a [TAMANHO][TAMANHO];
    logic [LARGURA-1:0] mem_b [TAMANHO][TAMANHO];

    logic               valido, hs, ultimo_pos, aceita, wr_ok;
    logic [LARGURA:0]   soma, dif, res;
    logic [LARGURA-1:0] dado;

    assign valido     = (estado_q == CALC);
    assign hs         = valido & bus.out_ready;
    assign ultimo_pos = (lin_q == ULT) && (col_q == ULT);
    assign aceita     = (estado_q == IDLE) && bus.start;
    assign wr_ok      = bus.wr_en && (estado_q == IDLE) && !aceita;

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            IDLE: if (bus.start) estado_d = CALC;
            CALC: if (hs && ultimo_pos) estado_d = IDLE;
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= IDLE;
            lin_q    <= '0;
            col_q    <= '0;
            modo_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            done_q   <= hs && ultimo_pos;
            if (aceita) begin
                lin_q  <= '0;
                col_q  <= '0;
                modo_q <= bus.modo;
            end else if (hs) begin
                if (col_q == ULT) begin
                    col_q <= '0;
                    lin_q <= ultimo_pos ? '0 : lin_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    // Matching against every in-range (i,j) pair also drops out-of-range indices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAMANHO; i++)
                for (int j = 0; j < TAMANHO; j++) begin
                    mem_a[i][j] <= '0;
                    mem_b[i][j] <= '0;
                end
        end else if (wr_ok) begin
            for (int i = 0; i < TAMANHO; i++)
                for (int j = 0; j < TAMANHO; j++)
                    if (bus.wr_lin == IW'(i) && bus.wr_col == IW'(j)) begin
                        if (bus.wr_sel) mem_b[i][j] <= bus.wr_dado;
                        else            mem_a[i][j] <= bus.wr_dado;
                    end
        end
    end

    // Bit LARGURA is the carry for add and the borrow (A < B) for subtract.
    always_comb begin
        soma = {1'b0, mem_a[lin_q][col_q]} + {1'b0, mem_b[lin_q][col_q]};
        dif  = {1'b0, mem_a[lin_q][col_q]} - {1'b0, mem_b[lin_q][col_q]};
        res  = modo_q ? dif : soma;
`ifdef MATRIZ_SOMA_SATURATE_EN
        if (res[LARGURA]) dado = modo_q ? '0 : '1;
        else              dado = res[LARGURA-1:0];
`else
        dado = res[LARGURA-1:0];
`endif
    end

    // Storage and indices are frozen while CALC waits, so a stall holds every output.
    assign bus.ocupado    = valido;
    assign bus.out_valid  = valido;
    assign bus.out_dado   = valido ? dado : '0;
    assign bus.out_lin    = lin_q;
    assign bus.out_col    = col_q;
    assign bus.out_ultimo = valido && ultimo_pos;
    assign bus.estouro    = valido && res[LARGURA];
    assign bus.done       = done_q;

endmodule

// File: tb/tb_matriz_soma_seq.sv
// Scoreboard bench for matriz_soma_seq (5x5, 8-bit): stimulus pushes expected elements,
// a negedge monitor pops and compares on every handshake and checks stall stability.
module tb_matriz_soma_seq;
    localparam int N = 5;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] dado;
        logic [2:0]   lin;
        logic [2:0]   col;
        logic         ultimo;
        logic         estouro;
    } elem_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matriz_soma_seq_if #(.TAMANHO(N), .LARGURA(W)) bus ();
    matriz_soma_seq #(.TAMANHO(N), .LARGURA(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    elem_t        exp_q[$];
    logic [W-1:0] ma [N][N];
    logic [W-1:0] mb [N][N];
    int           n_chk = 0;
    int           n_fail = 0;
    int           hs_cnt = 0;
    logic         rnd_ready = 1'b0;
    logic         ready_fix = 1'b1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, expv, $time);
        end
    endtask

    function automatic elem_t amostra();
        elem_t e;
        e.dado = bus.out_dado; e.lin = bus.out_lin; e.col = bus.out_col;
        e.ultimo = bus.out_ultimo; e.estouro = bus.estouro;
        return e;
    endfunction

    function automatic elem_t esperado(int i, int j, logic m);
        elem_t e;
        logic [W:0] r;
        r = m ? ({1'b0, ma[i][j]} - {1'b0, mb[i][j]}) : ({1'b0, ma[i][j]} + {1'b0, mb[i][j]});
        e.estouro = r[W];
`ifdef MATRIZ_SOMA_SATURATE_EN
        e.dado = r[W] ? (m ? 8'h00 : 8'hFF) : r[W-1:0];
`else
        e.dado = r[W-1:0];
`endif
        e.lin = 3'(i); e.col = 3'(j);
        e.ultimo = (i == N-1) && (j == N-1);
        return e;
    endfunction

    initial forever begin
        @(posedge clk); #1;
        bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    end

    // Monitor: pop on handshake, and a stalled element must not change.
    initial begin
        elem_t held, got, e;
        logic stalled;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else if (bus.out_valid) begin
                got = amostra();
                if (stalled) chk("stall_hold", 32'(got), 32'(held));
                if (bus.out_ready) begin
                    hs_cnt++;
                    stalled = 1'b0;
                    if (exp_q.size() == 0) chk("unexpected_elem", 32'(got), 32'hDEAD);
                    else begin
                        e = exp_q.pop_front();
                        chk("elem", 32'(got), 32'(e));
                    end
                end else begin
                    held = got;
                    stalled = 1'b1;
                end
            end
        end
    end

    task automatic wr(input logic sel, input int lin, input int col, input logic [W-1:0] d);
        bus.wr_en = 1'b1; bus.wr_sel = sel;
        bus.wr_lin = 3'(lin); bus.wr_col = 3'(col); bus.wr_dado = d;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        if (lin < N && col < N) begin
            if (sel) mb[lin][col] = d; else ma[lin][col] = d;
        end
    endtask

    task automatic esperar_done();
        logic visto;
        visto = 1'b0;
        for (int k = 0; k < 400 && !visto; k++) begin
            @(posedge clk); #1;
            visto = bus.done;
        end
        chk("done_seen", 32'(visto), 32'd1);
        chk("ocupado_at_done", 32'(bus.ocupado), 32'd0);
        chk("valid_at_done", 32'(bus.out_valid), 32'd0);
        chk("hs_count", hs_cnt, N*N);
        chk("queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(bus.done), 32'd0);
    endtask

    // neg: write with start, then mid-run start/modo/write that must all be ignored.
    task automatic operar(input logic m, input bit neg, input bit esperar);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) exp_q.push_back(esperado(i, j, m));
        hs_cnt = 0;
        bus.start = 1'b1; bus.modo = m;
        if (neg) begin
            bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_lin = 3'd2; bus.wr_col = 3'd2; bus.wr_dado = 8'h77;
        end
        chk("ocupado_before", 32'(bus.ocupado), 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.wr_en = 1'b0;
        chk("ocupado_after_start", 32'(bus.ocupado), 32'd1);
        chk("valid_after_start", 32'(bus.out_valid), 32'd1);
        if (neg) begin
            repeat (3) @(posedge clk);
            #1;
            bus.start = 1'b1; bus.modo = ~m;
            bus.wr_en = 1'b1; bus.wr_sel = 1'b1; bus.wr_lin = 3'd0; bus.wr_col = 3'd0; bus.wr_dado = 8'h55;
            @(posedge clk); #1;
            bus.start = 1'b0; bus.wr_en = 1'b0; bus.modo = m;
        end
        if (esperar) esperar_done();
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_lin = '0; bus.wr_col = '0; bus.wr_dado = '0;
        bus.start = 1'b0; bus.modo = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin ma[i][j] = '0; mb[i][j] = '0; end
        #2;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ocupado_done", {bus.ocupado, bus.done}, 32'd0);
        chk("rst_data", {bus.out_dado, bus.estouro, bus.out_ultimo, bus.out_lin, bus.out_col}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All 4+4: 25 x 0x08.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin wr(0, i, j, 8'd4); wr(1, i, j, 8'd4); end
        operar(1'b0, 0, 1);

        // Carry on (0,0).
        wr(0, 0, 0, 8'hF0); wr(1, 0, 0, 8'h20);
        operar(1'b0, 0, 1);

        // Subtract with borrow on (1,2), plain on (0,0); out-of-range writes dropped.
        wr(0, 0, 0, 8'd9); wr(1, 0, 0, 8'd2);
        wr(0, 1, 2, 8'd3); wr(1, 1, 2, 8'd5);
        wr(0, 5, 0, 8'hAA); wr(1, 0, 7, 8'hAA);
        operar(1'b1, 1, 1);

        // Pseudo-random backpressure, A[i][j]=i*5+j, B=1.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin wr(0, i, j, 8'(i*5+j)); wr(1, i, j, 8'd1); end
        rnd_ready = 1'b1;
        operar(1'b0, 1, 1);
        rnd_ready = 1'b0;
        @(posedge clk); #1;

        // Reset after the 10th handshake.
        operar(1'b0, 0, 0);
        begin
            bit ok;
            ok = 0;
            for (int k = 0; k < 200 && !ok; k++) begin
                @(posedge clk); #1;
                ok = (hs_cnt >= 10);
            end
            chk("reach_10_hs", 32'(ok), 32'd1);
        end
        rst_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin ma[i][j] = '0; mb[i][j] = '0; end
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_ocupado", 32'(bus.ocupado), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_no_done", 32'(bus.done), 32'd0);
        operar(1'b0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
